box_animator: RTL and testbench
===============================

Name: box_animator

Overview:
- Upstream command sequencer for the 4x4 box drawer stage.
- Generates the drawer's strobe handshakes (load-X, plot-box, black), its coordinate bus and its colour, so that a single box bounces around the screen.
- Per step: erase the old box (colour 000), move it one pixel diagonally with wall bounce, draw the new box. Steps are paced by a frame-rate divider.
- Sits between the board switches/keys and the drawer; the drawer's oDone output feeds back in as iDone.

Parameters:
- FRAME_DIV, 833333: iClock cycles per frame tick (60 Hz at 50 MHz).
- FRAMES_PER_STEP, 15: frame ticks between movement steps.
- X_MAX, 7'd123: largest legal box X. Box X range is 0..X_MAX on the 7-bit bus.
- Y_MAX, 7'd116: largest legal box Y. Box Y range is 0..Y_MAX.
- STROBE_LEN, 2: cycles each handshake phase is held.

Ports:
- iClock, in, 1: system clock.
- iReset, in, 1: reset. Asynchronous, active-high.
- iEnable, in, 1: run animation.
- iColour, in, 3: box colour for draw passes.
- iDone, in, 1: drawer oDone.
- oLoadX, out, 1: to drawer iLoadX.
- oPlotBox, out, 1: to drawer iPlotBox.
- oBlack, out, 1: to drawer iBlack.
- oXY_Coord, out, 7: to drawer iXY_Coord.
- oColour, out, 3: to drawer iColour.
- oBusy, out, 1: a drawer command is in flight.
- oBoxX, out, 7: current box X.
- oBoxY, out, 7: current box Y.

Behaviour:
- Reset (async, iReset=1), all of the following take these values immediately:
  - State = S_IDLE.
  - All strobes = 0; oXY_Coord = 0; oColour = 0; oBusy = 0.
  - x = 0, y = 0, dx = +1, dy = +1.
  - Step counter = 0, frame divider = 0.
- Reset mid-command: strobes drop in the same cycle. Recovery requires the drawer to be reset concurrently; this is a system-level rule.
- Frame divider: free-running 0..FRAME_DIV-1. frame_tick is a 1-cycle pulse on wrap.
- Main FSM:
  - S_IDLE: if iEnable, go to S_CLEAR.
  - S_CLEAR: black command (cmd sub-FSM). When it completes, go to S_DRAW.
  - S_DRAW: plot command at (x, y) with colour = iColour, sampled at command start. Then go to S_WAIT.
  - S_WAIT: count frame ticks. At FRAMES_PER_STEP ticks, clear the count:
    - iEnable=1: go to S_ERASE.
    - iEnable=0: go to S_IDLE. The box stays drawn. Re-enable goes through S_CLEAR.
  - S_ERASE: plot command at (x, y) with colour 000. Then go to S_MOVE.
  - S_MOVE, 1 cycle, X axis:
    - if dx=+1 and x==X_MAX: dx <= -1, x <= X_MAX-1.
    - else if dx=-1 and x==0: dx <= +1, x <= 1.
    - else x <= x+dx.
  - S_MOVE, Y axis: same rule with Y_MAX. Both axes update in the same cycle. Next state is S_DRAW.
- Command sub-FSM. Each phase lasts STROBE_LEN cycles. oBusy=1 from the first phase through completion.
  - Plot command phases:
    - C_X_HI: oXY=x, oLoadX=1.
    - C_X_LO: oXY=x, strobes 0.
    - C_Y_SET: oXY=y, oColour valid.
    - C_Y_HI: oXY=y, oPlotBox=1.
    - C_Y_LO: oXY=y, strobes 0.
    - C_WAIT_BUSY: wait iDone==0.
    - C_WAIT_DONE: wait iDone==1. Then complete.
  - Black command phases:
    - C_B_HI: oBlack=1, oColour=0.
    - C_B_LO: strobes 0.
    - Then C_WAIT_BUSY, C_WAIT_DONE.
  - oXY and oColour are held stable from C_Y_SET through C_WAIT_DONE.
  - Never more than one strobe high at a time.
  - Rising-edge-only waits are forbidden. The drawer's done stays high across its wait states, so completion requires a low-then-high iDone sequence.
- No timeout. A stuck drawer leaves oBusy high indefinitely.
- A frame_tick during a command is not counted. Counting happens only in S_WAIT.
- oBoxX/oBoxY are always the registered x/y.

Decomposition:
- Shared package (anim_pkg):
  - Main and command state enums.
  - BOX_SIZE=4.
  - SCREEN_W=160, SCREEN_H=120.
  - Direction encoding (0=+1, 1=-1).
- One sub-module: frame_ticker, which holds the FRAME_DIV divider and emits frame_tick.
- Main FSM, command FSM and position registers live in box_animator.

Test Plan:
- Bench setup: FRAME_DIV=4, FRAMES_PER_STEP=2, STROBE_LEN=2. The drawer is a behavioural model that drops done 3 cycles after the plot/black strobe releases and raises it 16 cycles later.
- Scenario 1: reset, iEnable=1, iColour=3'b101 → one oBlack pulse of 2 cycles. Then oLoadX high 2 cycles with oXY=0. Then oPlotBox high 2 cycles with oXY=0 and oColour=101.
- Scenario 2: continue running → sequence is erase at (0,0) with colour 000, then draw at (1,1) with colour 101. oBoxX/oBoxY=1/1 after S_MOVE.
- Scenario 3: preload x=123, dx=+1 via a run of 123 steps (or force) → next position x=122, dx=-1. Likewise y=116 → 115.
- Scenario 4: x=0, dx=-1 → x=1, dx=+1. Corner case x=0/y=0 with both directions negative flips both axes in the same cycle.
- Scenario 5: model holds iDone=1 throughout a command → FSM stays in C_WAIT_BUSY, oBusy=1, no new strobes.
- Scenario 6:
  - iReset pulsed asynchronously during C_Y_HI → oPlotBox=0 and all outputs at reset values before the next iClock edge.
  - iEnable=0 during S_WAIT → after the step count, enters S_IDLE with no erase.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and helpers for the bouncing-box command sequencer.
package anim_pkg;

    localparam int BOX_SIZE = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } main_state_t;

    typedef enum logic [3:0] {
        C_IDLE,
        C_X_HI,
        C_X_LO,
        C_Y_SET,
        C_Y_HI,
        C_Y_LO,
        C_B_HI,
        C_B_LO,
        C_WAIT_BUSY,
        C_WAIT_DONE
    } cmd_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    typedef struct packed {
        dir_t       dir;
        logic [6:0] pos;
    } axis_t;

    // One movement step on a single axis, bouncing off 0 and max.
    function automatic axis_t step_axis(input logic [6:0] pos, input dir_t dir,
                                        input logic [6:0] max);
        axis_t r;
        if (dir == DIR_POS && pos == max) begin
            r.dir = DIR_NEG;
            r.pos = max - 7'd1;
        end else if (dir == DIR_NEG && pos == 7'd0) begin
            r.dir = DIR_POS;
            r.pos = 7'd1;
        end else begin
            r.dir = dir;
            r.pos = (dir == DIR_POS) ? pos + 7'd1 : pos - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/box_animator_if.sv
// Strobe/coordinate bus between the animator and the 4x4 box drawer.
interface box_animator_if;
    logic       oLoadX;
    logic       oPlotBox;
    logic       oBlack;
    logic [6:0] oXY_Coord;
    logic [2:0] oColour;
    logic       iDone;

    modport master (output oLoadX, oPlotBox, oBlack, oXY_Coord, oColour, input iDone);
    modport slave  (input oLoadX, oPlotBox, oBlack, oXY_Coord, oColour, output iDone);
endinterface

// File: rtl/box_animator_frame_ticker.sv
// Free-running frame divider; tick pulses for one cycle on each wrap.
module frame_ticker #(
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(FRAME_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/box_animator.sv
// Bouncing-box sequencer: erase, move, redraw each step via drawer strobe commands.
module box_animator
    import anim_pkg::*;
#(
    parameter int unsigned FRAME_DIV       = 833333,
    parameter int unsigned FRAMES_PER_STEP = 15,
    parameter logic [6:0]  X_MAX           = 7'd123,
    parameter logic [6:0]  Y_MAX           = 7'd116,
    parameter int unsigned STROBE_LEN      = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic [2:0]            iColour,
    box_animator_if.master        drw,
    output logic                  oBusy,
    output logic [6:0]            oBoxX,
    output logic [6:0]            oBoxY
);
    localparam int PW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    main_state_t   state;
    cmd_state_t    cmd;
    logic [PW-1:0] ph;
    logic [SW-1:0] steps;
    logic [6:0]    x, y;
    dir_t          dx, dy;
    logic          frame_tick;
    logic          ph_last;
    logic          cmd_done;
    axis_t         nx, ny;

    frame_ticker #(.FRAME_DIV(FRAME_DIV)) u_ticker (
        .clk  (iClock),
        .rst  (iReset),
        .tick (frame_tick)
    );

    assign ph_last  = (ph == PW'(STROBE_LEN - 1));
    assign cmd_done = (cmd == C_WAIT_DONE) && drw.iDone;
    assign nx       = step_axis(x, dx, X_MAX);
    assign ny       = step_axis(y, dy, Y_MAX);
    assign oBoxX    = x;
    assign oBoxY    = y;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state         <= S_IDLE;
            cmd           <= C_IDLE;
            ph            <= '0;
            steps         <= '0;
            x             <= '0;
            y             <= '0;
            dx            <= DIR_POS;
            dy            <= DIR_POS;
            drw.oLoadX    <= 1'b0;
            drw.oPlotBox  <= 1'b0;
            drw.oBlack    <= 1'b0;
            drw.oXY_Coord <= '0;
            drw.oColour   <= '0;
            oBusy         <= 1'b0;
        end else begin
            // Command-owning states launch their command while cmd is idle,
            // then advance once the command sub-FSM reports completion.
            case (state)
                S_IDLE: if (iEnable) state <= S_CLEAR;
                S_CLEAR: begin
                    if (cmd == C_IDLE) begin
                        cmd         <= C_B_HI;
                        ph          <= '0;
                        drw.oBlack  <= 1'b1;
                        drw.oColour <= '0;
                        oBusy       <= 1'b1;
                    end else if (cmd_done) begin
                        state <= S_DRAW;
                    end
                end
                S_DRAW, S_ERASE: begin
                    if (cmd == C_IDLE) begin
                        cmd           <= C_X_HI;
                        ph            <= '0;
                        drw.oLoadX    <= 1'b1;
                        drw.oXY_Coord <= x;
                        drw.oColour   <= (state == S_DRAW) ? iColour : 3'b000;
                        oBusy         <= 1'b1;
                    end else if (cmd_done) begin
                        state <= (state == S_DRAW) ? S_WAIT : S_MOVE;
                    end
                end
                S_WAIT: begin
                    if (frame_tick) begin
                        if (steps == SW'(FRAMES_PER_STEP - 1)) begin
                            steps <= '0;
                            state <= iEnable ? S_ERASE : S_IDLE;
                        end else begin
                            steps <= steps + SW'(1);
                        end
                    end
                end
                S_MOVE: begin
                    x     <= nx.pos;
                    dx    <= nx.dir;
                    y     <= ny.pos;
                    dy    <= ny.dir;
                    state <= S_DRAW;
                end
                default: state <= S_IDLE;
            endcase

            if (cmd inside {C_X_HI, C_X_LO, C_Y_SET, C_Y_HI, C_Y_LO, C_B_HI, C_B_LO})
                ph <= ph_last ? '0 : ph + PW'(1);

            case (cmd)
                C_X_HI: if (ph_last) begin
                    cmd        <= C_X_LO;
                    drw.oLoadX <= 1'b0;
                end
                C_X_LO: if (ph_last) begin
                    cmd           <= C_Y_SET;
                    drw.oXY_Coord <= y;
                end
                C_Y_SET: if (ph_last) begin
                    cmd          <= C_Y_HI;
                    drw.oPlotBox <= 1'b1;
                end
                C_Y_HI: if (ph_last) begin
                    cmd          <= C_Y_LO;
                    drw.oPlotBox <= 1'b0;
                end
                C_Y_LO: if (ph_last) cmd <= C_WAIT_BUSY;
                C_B_HI: if (ph_last) begin
                    cmd        <= C_B_LO;
                    drw.oBlack <= 1'b0;
                end
                C_B_LO: if (ph_last) cmd <= C_WAIT_BUSY;
                C_WAIT_BUSY: if (!drw.iDone) cmd <= C_WAIT_DONE;
                C_WAIT_DONE: if (drw.iDone) begin
                    cmd   <= C_IDLE;
                    oBusy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_box_animator.sv
// Scoreboard bench: expected drawer commands are queued by stimulus and popped by a monitor.
module tb_box_animator;
    localparam int FD    = 4;
    localparam int FPS   = 2;
    localparam int SL    = 2;
    localparam int XM    = 123;
    localparam int YM    = 116;
    localparam int NSTEP = 250;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] col;
    logic       busy;
    logic [6:0] bx, by;
    logic       stuck;

    box_animator_if bus ();

    box_animator #(
        .FRAME_DIV       (FD),
        .FRAMES_PER_STEP (FPS),
        .STROBE_LEN      (SL)
    ) dut (
        .iClock  (clk),
        .iReset  (rst),
        .iEnable (en),
        .iColour (col),
        .drw     (bus.master),
        .oBusy   (busy),
        .oBoxX   (bx),
        .oBoxY   (by)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_black;
        int x;
        int y;
        int colour;
    } cmd_t;

    cmd_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bounce position after n steps: a triangle wave of period 2*m.
    function automatic int tri_pos(input int n, input int m);
        int p;
        p = n % (2 * m);
        return (p > m) ? 2 * m - p : p;
    endfunction

    task automatic push_black();
        cmd_t e;
        e.is_black = 1'b1; e.x = 0; e.y = 0; e.colour = 0;
        q.push_back(e);
    endtask

    task automatic push_plot(input int n, input int c);
        cmd_t e;
        e.is_black = 1'b0; e.x = tri_pos(n, XM); e.y = tri_pos(n, YM); e.colour = c;
        q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d commands outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    // Behavioural drawer: done drops 3 cycles after a plot/black strobe releases, rises 16 later.
    initial begin
        bit sp;
        sp = 1'b0;
        bus.iDone = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (sp && !(bus.oPlotBox || bus.oBlack)) begin
                repeat (3) begin @(posedge clk); #1; end
                while (stuck) begin @(posedge clk); #1; end
                bus.iDone = 1'b0;
                repeat (16) begin @(posedge clk); #1; end
                bus.iDone = 1'b1;
            end
            sp = bus.oPlotBox || bus.oBlack;
        end
    end

    // Monitor: pop and compare on every plot/black strobe rise; check strobe widths.
    int  lx_cnt, pb_cnt, bk_cnt, x_cap;
    bit  pl, pp, pk;
    always @(negedge clk) begin
        cmd_t e;
        if (rst) begin
            lx_cnt = 0; pb_cnt = 0; bk_cnt = 0;
            pl = 0; pp = 0; pk = 0;
        end else begin
            if (bus.oLoadX && !pl) x_cap = int'(bus.oXY_Coord);
            if ((bus.oPlotBox && !pp) || (bus.oBlack && !pk)) begin
                chk("one_strobe", int'(bus.oLoadX) + int'(bus.oPlotBox) + int'(bus.oBlack), 1);
                if (q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("cmd_is_black", int'(bus.oBlack), int'(e.is_black));
                    chk("cmd_colour", int'(bus.oColour), e.colour);
                    if (!e.is_black) begin
                        chk("plot_x", x_cap, e.x);
                        chk("plot_y", int'(bus.oXY_Coord), e.y);
                        chk("box_x", int'(bx), e.x);
                        chk("box_y", int'(by), e.y);
                    end
                end
            end
            if (bus.oLoadX) lx_cnt++; else if (pl) begin chk("loadx_len", lx_cnt, SL); lx_cnt = 0; end
            if (bus.oPlotBox) pb_cnt++; else if (pp) begin chk("plot_len", pb_cnt, SL); pb_cnt = 0; end
            if (bus.oBlack) bk_cnt++; else if (pk) begin chk("black_len", bk_cnt, SL); bk_cnt = 0; end
            pl = bus.oLoadX; pp = bus.oPlotBox; pk = bus.oBlack;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_loadx"}, int'(bus.oLoadX), 0);
        chk({tag, "_plot"},  int'(bus.oPlotBox), 0);
        chk({tag, "_black"}, int'(bus.oBlack), 0);
        chk({tag, "_xy"},    int'(bus.oXY_Coord), 0);
        chk({tag, "_colour"}, int'(bus.oColour), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_boxx"},  int'(bx), 0);
        chk({tag, "_boxy"},  int'(by), 0);
    endtask

    initial begin
        int c;
        rst = 1'b1; en = 1'b0; col = 3'b000; stuck = 1'b0;
        #3;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Startup: clear then draw at the origin.
        c = 5;
        col = 3'(c);
        push_black();
        push_plot(0, c);
        en = 1'b1;
        wait_empty("startup");

        // Run far enough to bounce off X_MAX, Y_MAX, Y=0 and X=0.
        for (int n = 1; n <= NSTEP; n++) begin
            push_plot(n - 1, 0);
            push_plot(n, c);
            wait_empty("step");
            c = int'($urandom_range(0, 7));
            col = 3'(c);
        end

        // Disable during the wait: no erase, box remains in place.
        en = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        chk("idle_busy", int'(busy), 0);
        chk("idle_boxx", int'(bx), tri_pos(NSTEP, XM));
        chk("idle_boxy", int'(by), tri_pos(NSTEP, YM));

        // Re-enable goes through a clear.
        push_black();
        push_plot(NSTEP, c);
        en = 1'b1;
        wait_empty("reenable");

        // Drawer holds done high: command must stall with busy set.
        stuck = 1'b1;
        repeat (150) @(posedge clk);
        #2;
        chk("stuck_busy", int'(busy), 1);
        chk("stuck_loadx", int'(bus.oLoadX), 0);
        chk("stuck_plot", int'(bus.oPlotBox), 0);
        push_plot(NSTEP, 0);
        push_plot(NSTEP + 1, c);
        stuck = 1'b0;
        wait_empty("unstuck");

        // Async reset while the erase plot strobe is high.
        push_plot(NSTEP + 1, 0);
        wait_empty("pre_reset");
        chk("plot_high_before_reset", int'(bus.oPlotBox), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("postreset_busy", int'(busy), 0);

        c = int'($urandom_range(0, 7));
        col = 3'(c);
        push_black();
        push_plot(0, c);
        en = 1'b1;
        wait_empty("restart");
        push_plot(0, 0);
        push_plot(1, c);
        wait_empty("restart_step");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
